// File: rtl/shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-add multiplier. Consumes one multiplier bit per clock and
// stops early once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 mul_done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   next_acc;
    logic                 calc_last;

    assign next_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The count bound is only a safety net; the zero-remainder test fires first or together.
    assign calc_last = ((mplier_q >> 1) == '0) || (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (calc_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, multiplicand};
                    mplier_d = multiplier;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            StCalc: begin
                acc_d    = next_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (calc_last) begin
                    product_d = next_acc;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign mul_done = done_q;
    assign product  = product_q;

endmodule
